// File: rtl/bit_select_pkg.sv
// Shared definitions for the multi-cycle bit-utility blocks: state encoding and
// width derivations from ORDER.
package bit_select_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic int word_w(input int order);
        return 1 << order;
    endfunction

    // Level counter width; ORDER = 1 still needs a one-bit register.
    function automatic int lvl_w(input int order);
        return (order > 1) ? $clog2(order) : 1;
    endfunction

endpackage

// File: rtl/bit_select_if.sv
// Request/response handshake bundle for bit_select; the master drives requests
// and takes results, the slave is the block itself.
interface bit_select_if #(
    parameter int ORDER = 3
) ();
    import bit_select_pkg::*;

    localparam int W = word_w(ORDER);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_word;
    logic [ORDER-1:0] in_rank;
    logic             out_valid;
    logic             out_ready;
    logic [ORDER-1:0] out_pos;
    logic             out_none;

    modport master (
        output in_valid, in_word, in_rank, out_ready,
        input  in_ready, out_valid, out_pos, out_none
    );

    modport slave (
        input  in_valid, in_word, in_rank, out_ready,
        output in_ready, out_valid, out_pos, out_none
    );

endinterface

// File: rtl/bit_select_popcount.sv
// Combinational population count of a 2**ORDER-bit word; result is ORDER+1
// bits so an all-ones word fits.
module bit_select_popcount
    import bit_select_pkg::*;
#(
    parameter int ORDER = 3
) (
    input  logic [word_w(ORDER)-1:0] word,
    output logic [ORDER:0]           count
);

    localparam int W = word_w(ORDER);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + (ORDER+1)'(word[i]);
        end
    end

endmodule

// File: rtl/bit_select.sv
// Rank-to-position decoder: finds the index of the k-th set bit of a word by a
// binary search of one level per clock, with valid/ready on both sides.
module bit_select
    import bit_select_pkg::*;
#(
    parameter int ORDER = 3
) (
    input  logic         clock,
    input  logic         reset,
    bit_select_if.slave  bus
);

    localparam int W  = word_w(ORDER);
    localparam int LW = lvl_w(ORDER);

    state_e           state_q, state_d;
    logic [W-1:0]     win_q, win_d;
    logic [ORDER-1:0] rem_q, rem_d;
    logic [ORDER-1:0] base_q, base_d;
    logic [LW-1:0]    level_q, level_d;
    logic             none_q, none_d;

    logic [ORDER:0]   in_cnt;
    logic [ORDER:0]   low_cnt;
    logic [W-1:0]     low_mask;
    logic [W-1:0]     low_word;
    logic [ORDER-1:0] half;
    logic             take_low;
    logic             last_step;
    logic             accept;

    bit_select_popcount #(.ORDER(ORDER)) u_pc_in (
        .word  (bus.in_word),
        .count (in_cnt)
    );

    bit_select_popcount #(.ORDER(ORDER)) u_pc_low (
        .word  (low_word),
        .count (low_cnt)
    );

    always_comb begin
        half     = ORDER'(1) << level_q;
        low_mask = '0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(half)) low_mask[i] = 1'b1;
        end
        low_word  = win_q & low_mask;
        take_low  = {1'b0, rem_q} < low_cnt;
        last_step = (level_q == '0);
    end

    assign accept = bus.in_valid & bus.in_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            rem_q   <= '0;
            base_q  <= '0;
            level_q <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rem_q   <= rem_d;
            base_q  <= base_d;
            level_q <= level_d;
            none_q  <= none_d;
        end
    end

    // A none request still dwells one cycle in SEARCH (with the search
    // suppressed) so its result appears one edge after the accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SEARCH;
            ST_SEARCH: if (none_q || last_step) state_d = ST_DONE;
            ST_DONE:   if (bus.out_ready) state_d = accept ? ST_SEARCH : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_d   = win_q;
        rem_d   = rem_q;
        base_d  = base_q;
        level_d = level_q;
        none_d  = none_q;
        if (accept) begin
            win_d   = bus.in_word;
            rem_d   = bus.in_rank;
            base_d  = '0;
            level_d = LW'(ORDER - 1);
            none_d  = (in_cnt <= {1'b0, bus.in_rank});
        end else if (state_q == ST_SEARCH && !none_q) begin
            if (take_low) begin
                win_d = low_word;
            end else begin
                // rem >= c here, so c fits in ORDER bits and cannot underflow
                rem_d  = rem_q - low_cnt[ORDER-1:0];
                base_d = base_q + half;
                win_d  = win_q >> half;
            end
            if (!last_step) level_d = level_q - 1'b1;
        end
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
        bus.out_valid = (state_q == ST_DONE);
        bus.out_pos   = base_q;
        bus.out_none  = none_q;
    end

endmodule

// File: tb/tb_bit_select.sv
// Scoreboarded random/directed bench for bit_select; a reference scan from the
// LSB supplies expected position, none flag and latency.
module tb_bit_select;
    import bit_select_pkg::*;

    localparam int ORDER = 3;

    typedef struct {
        logic [2:0] pos;
        logic       none;
        int         acc;
        logic [7:0] word;
        logic [2:0] rank;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bit_select_if #(.ORDER(ORDER)) bus ();
    bit_select #(.ORDER(ORDER)) dut (.clock(clock), .reset(reset), .bus(bus));

    bit_select_if #(.ORDER(1)) bus1 ();
    bit_select #(.ORDER(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_mode = 1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic void ref_model(input logic [7:0] w, input int k,
                                      output logic [2:0] pos, output logic none);
        int seen;
        seen = 0;
        pos  = '0;
        none = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (w[i] && none) begin
                if (seen == k) begin
                    pos  = 3'(i);
                    none = 1'b0;
                end
                seen++;
            end
        end
    endfunction

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'($urandom_range(0, 1));
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [7:0] w, input logic [2:0] k);
        exp_t e;
        bit   got;
        int   t;
        got = 0;
        t   = 0;
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        bus.in_rank  = k;
        while (!got) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ref_model(w, int'(k), e.pos, e.none);
                e.acc  = cyc + 1;
                e.word = w;
                e.rank = k;
                sb.push_back(e);
                got = 1;
            end
            @(posedge clock);
            #1;
            if (++t > 300 && !got) begin
                fail_now("accept_timeout");
                got = 1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(posedge clock);
            t++;
        end
        #1;
        if (sb.size() != 0) fail_now("drain");
    endtask

    // Monitor: latency, stability under backpressure, scoreboard compare
    logic       prev_v = 1'b0;
    logic       hold = 1'b0;
    int         rise = 0;
    logic [2:0] last_pos;
    logic       last_none;

    always @(negedge clock) begin
        if (reset) begin
            prev_v = 1'b0;
            hold   = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) rise = cyc;
            if (hold && bus.out_valid) begin
                chk("stable_pos", 32'(bus.out_pos), 32'(last_pos));
                chk("stable_none", 32'(bus.out_none), 32'(last_none));
            end
            if (bus.out_valid && !bus.out_ready)
                chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                chk("consume_in_ready", 32'(bus.in_ready), 32'd1);
                if (sb.size() == 0) begin
                    fail_now("unexpected_out");
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("pos w=%02h k=%0d", mon_e.word, mon_e.rank),
                        32'(bus.out_pos), 32'(mon_e.pos));
                    chk($sformatf("none w=%02h k=%0d", mon_e.word, mon_e.rank),
                        32'(bus.out_none), 32'(mon_e.none));
                    chk($sformatf("latency w=%02h k=%0d", mon_e.word, mon_e.rank),
                        32'(rise - mon_e.acc), mon_e.none ? 32'd1 : 32'(ORDER));
                end
                hold = 1'b0;
            end else begin
                hold = bus.out_valid;
            end
            last_pos  = bus.out_pos;
            last_none = bus.out_none;
            prev_v    = bus.out_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.in_rank   = '0;
        bus1.in_valid = 1'b0;
        bus1.in_word  = '0;
        bus1.in_rank  = '0;
        bus1.out_ready = 1'b1;

        repeat (2) @(negedge clock);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pos", 32'(bus.out_pos), 32'd0);
        chk("rst_out_none", 32'(bus.out_none), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);

        // Directed cases, back-to-back with out_ready high
        ready_mode = 1;
        for (int k = 0; k < 4; k++) send(8'hB4, 3'(k));
        send(8'hFF, 3'd7);
        send(8'h01, 3'd0);
        send(8'h00, 3'd0);
        send(8'h80, 3'd1);
        wait_drain();

        // Backpressure, then consume and accept on the same edge
        ready_mode = 2;
        idle(2);
        send(8'hB4, 3'd1);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!bus.out_valid) fail_now("bp_valid_wait");
        idle(5);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_pos", 32'(bus.out_pos), 32'd4);
        fork
            send(8'hB4, 3'd3);
            begin
                idle(1);
                ready_mode = 1;
            end
        join
        wait_drain();

        // Reset during the second SEARCH cycle
        send(8'hC3, 3'd1);
        idle(1);
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clock);
        #1;
        send(8'h5A, 3'd2);
        wait_drain();

        // Exhaustive sweep with random out_ready and occasional gaps
        ready_mode = 0;
        for (int w = 0; w < 256; w++) begin
            for (int k = 0; k < 8; k++) begin
                send(8'(w), 3'(k));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        for (int n = 0; n < 200; n++) begin
            send(8'($urandom), 3'($urandom_range(0, 7)));
            idle($urandom_range(0, 2));
        end
        ready_mode = 1;
        wait_drain();

        // ORDER = 1 instance
        bus1.in_valid = 1'b1;
        bus1.in_word  = 2'b10;
        bus1.in_rank  = 1'b0;
        @(negedge clock);
        chk("o1_in_ready_a", 32'(bus1.in_ready), 32'd1);
        @(posedge clock);
        #1;
        bus1.in_valid = 1'b0;
        @(negedge clock);
        chk("o1_early_valid_a", 32'(bus1.out_valid), 32'd0);
        @(negedge clock);
        chk("o1_valid_a", 32'(bus1.out_valid), 32'd1);
        chk("o1_pos_a", 32'(bus1.out_pos), 32'd1);
        chk("o1_none_a", 32'(bus1.out_none), 32'd0);
        @(posedge clock);
        #1;
        bus1.in_valid = 1'b1;
        bus1.in_rank  = 1'b1;
        @(negedge clock);
        chk("o1_in_ready_b", 32'(bus1.in_ready), 32'd1);
        @(posedge clock);
        #1;
        bus1.in_valid = 1'b0;
        @(negedge clock);
        chk("o1_early_valid_b", 32'(bus1.out_valid), 32'd0);
        @(negedge clock);
        chk("o1_valid_b", 32'(bus1.out_valid), 32'd1);
        chk("o1_none_b", 32'(bus1.out_none), 32'd1);
        chk("o1_pos_b", 32'(bus1.out_pos), 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_select.md
# bit_select

Sequential rank-to-position decoder: given a W-bit word and a rank k, returns the bit index of the k-th set bit (0-based, counted from the LSB), or flags that fewer than k+1 bits are set. It is the inverse of the population-count/rank path: popcount maps position to rank, this block maps rank back to position. It sits beside the bit-counting library as a multi-cycle unit with valid/ready handshakes on both sides, and performs a binary search of one level per clock.

## Interface

Parameters:
- ORDER, 3, log2 of word width; ORDER >= 1 required.
- W, 2**ORDER, word width; derived, not overridden.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts a request this cycle.
- in_word  in  W  word to search.
- in_rank  in  ORDER  rank k, 0..W-1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out_pos  out  ORDER  index of the k-th set bit; 0 when out_none.
- out_none  out  1  popcount(in_word) <= k.

## Operation

- States: IDLE, SEARCH, DONE.
- Accept: the transfer occurs on a rising edge with in_valid & in_ready. Capture word into win, capture rank into rem, set base = 0 and level = ORDER-1, and latch none = (popcount(in_word) <= in_rank).
  - If none: go to DONE with out_pos = 0 and out_none = 1.
  - Otherwise go to SEARCH.
- SEARCH step at level l, with half = 2**l:
  - c = popcount(win[half-1:0]).
  - If rem < c: keep the low half, win <= win & ((1<<half)-1), base unchanged.
  - Else: rem <= rem - c, base <= base + half, win <= win >> half.
  - Decrement level. When the step with l = 0 completes, go to DONE with out_pos = base and out_none = 0.
- DONE: out_valid = 1. out_pos and out_none stay stable until out_valid & out_ready.
- in_ready = (state == IDLE) | (state == DONE & out_ready). A new request may be accepted on the same edge the result is consumed (back-to-back).
- Arithmetic:
  - rem is ORDER bits wide.
  - c is ORDER+1 bits wide. Compare rem < c at ORDER+1 bits.
  - rem - c never underflows, because this branch is taken only when rem >= c.
  - base + half never exceeds W-1.

## Timing

- Reset values: state IDLE, in_ready 1, out_valid 0, out_pos 0, out_none 0; internal win, rem, base, level all 0.
- Latency from accept edge T:
  - Found case: out_valid rises after edge T+ORDER (ORDER search edges T+1..T+ORDER).
  - None case: out_valid rises after edge T+1.
- Throughput: one result per ORDER+1 cycles found, 2 cycles none, when out_ready is held high.
- Backpressure: with out_ready low, the block stays in DONE indefinitely, outputs are frozen, and in_ready is 0.
- in_valid while busy (SEARCH, or DONE without out_ready): not accepted. The producer must hold its data; the block ignores the inputs.
- Reset asserted mid-SEARCH or in DONE: immediately return to IDLE with out_valid 0. The pending result is discarded.
- in_rank >= popcount(in_word), including in_word = 0: treated as the none case. No search is performed.

## Structure

- Shared defines header: state encodings (IDLE, SEARCH, DONE) and the W = 2**ORDER derivation, shared with other multi-cycle bit-utility blocks.
- Sub-modules: reuse the existing popcount module twice.
  - Full width on in_word, for the none check.
  - Full width on the masked low half of win, for c.
  - No new sub-module is needed.
- Expected RTL size: ~150 lines.

## Test plan

ORDER = 3 unless stated.
- Word 8'b1011_0100: rank 0 -> pos 2, rank 1 -> pos 4, rank 2 -> pos 5, rank 3 -> pos 7, out_none 0 in every case, each out_valid 3 cycles after accept.
- Word 8'hFF rank 7 -> pos 7. Word 8'h01 rank 0 -> pos 0. Word 8'h00 rank 0 -> out_none 1 and pos 0, with out_valid 1 cycle after accept. Word 8'h80 rank 1 -> out_none 1.
- Backpressure: hold out_ready low 5 cycles after out_valid. out_pos and out_none are stable and in_ready is 0. Then raise out_ready with in_valid high: the new request is accepted on the same edge the old result is consumed.
- Reset pulse at the 2nd SEARCH cycle: out_valid stays 0. After release, in_ready is 1 and a fresh request (8'h5A, rank 2 -> pos 4) completes correctly.
- Exhaustive: for all 256 words × 8 ranks, compare against a behavioural model (scan from LSB counting ones). Check pos, none, and latency (3 found / 1 none), with out_ready randomly toggled.
- ORDER = 1 sanity: word 2'b10 rank 0 -> pos 1 after 1 cycle; rank 1 -> none.
